// File: rtl/nibble_serial_subtractor_if.sv
// rtl/nibble_serial_subtractor_if.sv - operand/result handshake bundle for nibble_serial_subtractor
//
// Purpose: groups the operand input channel (x, y, bin, in_valid/in_ready)
// and the result output channel (diff, bout, ovf, out_valid/out_ready).
// Optional macro: SUB_OVERFLOW_FLAG_EN adds the ovf signal.
// Modports:
//   master - producer of operands / consumer of results (e.g. testbench)
//   slave  - the subtractor itself
interface nibble_serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             bin;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             out_valid;
    logic             out_ready;
`ifdef SUB_OVERFLOW_FLAG_EN
    logic             ovf;

    modport master (
        output x, y, bin, in_valid, out_ready,
        input  in_ready, diff, bout, out_valid, ovf
    );
    modport slave (
        input  x, y, bin, in_valid, out_ready,
        output in_ready, diff, bout, out_valid, ovf
    );
`else
    modport master (
        output x, y, bin, in_valid, out_ready,
        input  in_ready, diff, bout, out_valid
    );
    modport slave (
        input  x, y, bin, in_valid, out_ready,
        output in_ready, diff, bout, out_valid
    );
`endif
endinterface

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - digit-serial subtractor, diff = x - y - bin
//
// Purpose: computes x - y - bin one DIGIT-bit slice per clock, LSB slice
// first, with the borrow registered between slices. One operation in flight.
// Optional macro: SUB_OVERFLOW_FLAG_EN enables the signed overflow flag ovf.
// Ports:
//   clk   - sole clock, rising edge
//   reset - synchronous, active-high
//   s     - nibble_serial_subtractor_if.slave: x, y, bin, in_valid, in_ready,
//           diff, bout, out_valid, out_ready (and ovf when enabled)
module nibble_serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    nibble_serial_subtractor_if.slave   s
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic             r_borrow;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [31:0]      w_base;
    logic [DIGIT-1:0] w_xs;
    logic [DIGIT-1:0] w_ys;
    logic [DIGIT:0]   w_sub;
    logic             w_last;

    // Current slice and its DIGIT+1-bit difference; the top bit is the borrow.
    assign w_base = 32'(r_count) * 32'(DIGIT);
    assign w_xs   = r_x[w_base +: DIGIT];
    assign w_ys   = r_y[w_base +: DIGIT];
    assign w_sub  = {1'b0, w_xs} - {1'b0, w_ys} - {{DIGIT{1'b0}}, r_borrow};
    assign w_last = (r_count == CW'(STEPS - 1));

`ifdef SUB_OVERFLOW_FLAG_EN
    logic r_ovf;
    assign s.ovf = r_ovf;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_borrow    <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (s.in_valid && r_in_ready) begin
                        r_x        <= s.x;
                        r_y        <= s.y;
                        r_borrow   <= s.bin;
                        r_count    <= '0;
                        r_diff     <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_diff[w_base +: DIGIT] <= w_sub[DIGIT-1:0];
                    r_borrow                <= w_sub[DIGIT];
                    r_count                 <= r_count + 1'b1;
                    if (w_last) begin
                        r_bout      <= w_sub[DIGIT];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
`ifdef SUB_OVERFLOW_FLAG_EN
                        // The top slice being written now carries the final diff MSB.
                        r_ovf <= (r_x[WIDTH-1] != r_y[WIDTH-1]) &&
                                 (w_sub[DIGIT-1] != r_x[WIDTH-1]);
`endif
                    end
                end
                S_DONE: begin
                    if (r_out_valid && s.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign s.in_ready  = r_in_ready;
    assign s.out_valid = r_out_valid;
    assign s.diff      = r_diff;
    assign s.bout      = r_bout;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb/tb_nibble_serial_subtractor.sv - directed self-checking bench for nibble_serial_subtractor
module tb_nibble_serial_subtractor;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    nibble_serial_subtractor_if #(.WIDTH(16)) u_if ();

    nibble_serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .s     (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one operand set, wait for out_valid; lat = edges after acceptance, -1 on timeout.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic bin,
                          output int lat);
        @(negedge clk);
        u_if.x = x; u_if.y = y; u_if.bin = bin; u_if.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (u_if.out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // Complete the output handshake, leaving the bench at a negedge.
    task automatic take_result();
        u_if.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({u_if.in_ready, u_if.out_valid, u_if.bout, u_if.diff} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL reset_state got in_ready=%b out_valid=%b bout=%b diff=%h exp 1 0 0 0000",
                     u_if.in_ready, u_if.out_valid, u_if.bout, u_if.diff);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] tx [6];
        logic [15:0] ty [6];
        logic        tb [6];
        logic [15:0] ed [6];
        logic        eb [6];
        int          lat;
        tx = '{16'h1234, 16'h0000, 16'h0005, 16'h4321, 16'h0000, 16'hFFFF};
        ty = '{16'h0034, 16'h0001, 16'h0005, 16'h4321, 16'h0000, 16'h0000};
        tb = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0};
        ed = '{16'h1200, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF};
        eb = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b1,     1'b0};
        for (int k = 0; k < 6; k++) begin
            run_op(tx[k], ty[k], tb[k], lat);
            checks++;
            if (lat !== 4) begin
                failures++;
                $display("FAIL latency[%0d] got=%0d exp=4", k, lat);
            end
            checks++;
            if (u_if.diff !== ed[k]) begin
                failures++;
                $display("FAIL diff[%0d] got=%h exp=%h", k, u_if.diff, ed[k]);
            end
            checks++;
            if (u_if.bout !== eb[k]) begin
                failures++;
                $display("FAIL bout[%0d] got=%b exp=%b", k, u_if.bout, eb[k]);
            end
            take_result();
            checks++;
            if ({u_if.out_valid, u_if.in_ready} !== 2'b01) begin
                failures++;
                $display("FAIL release[%0d] got out_valid=%b in_ready=%b exp 0 1",
                         k, u_if.out_valid, u_if.in_ready);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        run_op(16'hA5A5, 16'h1111, 1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            u_if.x = 16'h0F0F ^ 16'(i); u_if.y = 16'h0001; u_if.in_valid = i[0];
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({u_if.out_valid, u_if.in_ready, u_if.bout, u_if.diff} !== {1'b1, 1'b0, 1'b0, 16'h9494}) begin
                failures++;
                $display("FAIL hold[%0d] got out_valid=%b in_ready=%b bout=%b diff=%h exp 1 0 0 9494",
                         i, u_if.out_valid, u_if.in_ready, u_if.bout, u_if.diff);
            end
        end
        u_if.in_valid = 1'b0;
        take_result();
        checks++;
        if ({u_if.out_valid, u_if.in_ready, u_if.diff} !== {1'b0, 1'b1, 16'h9494}) begin
            failures++;
            $display("FAIL hold_release got out_valid=%b in_ready=%b diff=%h exp 0 1 9494",
                     u_if.out_valid, u_if.in_ready, u_if.diff);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        @(negedge clk);
        u_if.x = 16'hFFFF; u_if.y = 16'h0001; u_if.bin = 1'b0; u_if.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({u_if.out_valid, u_if.in_ready, u_if.diff} !== {1'b0, 1'b1, 16'h0000}) begin
            failures++;
            $display("FAIL mid_reset got out_valid=%b in_ready=%b diff=%h exp 0 1 0000",
                     u_if.out_valid, u_if.in_ready, u_if.diff);
        end
        run_op(16'h0010, 16'h0001, 1'b0, lat);
        checks++;
        if ({u_if.bout, u_if.diff} !== {1'b0, 16'h000F} || lat !== 4) begin
            failures++;
            $display("FAIL after_reset got lat=%0d bout=%b diff=%h exp 4 0 000F",
                     lat, u_if.bout, u_if.diff);
        end
        take_result();
    endtask

    // Next op accepted on the first edge after release: period STEPS+2.
    task automatic test_back_to_back();
        int lat;
        run_op(16'h0100, 16'h0001, 1'b0, lat);
        take_result();
        run_op(16'h0002, 16'h0003, 1'b0, lat);
        checks++;
        if ({u_if.bout, u_if.diff} !== {1'b1, 16'hFFFF} || lat !== 4) begin
            failures++;
            $display("FAIL back_to_back got lat=%0d bout=%b diff=%h exp 4 1 FFFF",
                     lat, u_if.bout, u_if.diff);
        end
        take_result();
    endtask

`ifdef SUB_OVERFLOW_FLAG_EN
    task automatic test_overflow();
        logic [15:0] tx [3];
        logic [15:0] ty [3];
        logic [15:0] ed [3];
        logic        eb [3];
        logic        eo [3];
        int          lat;
        tx = '{16'h8000, 16'h7FFF, 16'h1234};
        ty = '{16'h0001, 16'hFFFF, 16'h0034};
        ed = '{16'h7FFF, 16'h8000, 16'h1200};
        eb = '{1'b0,     1'b1,     1'b0};
        eo = '{1'b1,     1'b1,     1'b0};
        for (int k = 0; k < 3; k++) begin
            run_op(tx[k], ty[k], 1'b0, lat);
            checks++;
            if ({u_if.ovf, u_if.bout, u_if.diff} !== {eo[k], eb[k], ed[k]}) begin
                failures++;
                $display("FAIL ovf[%0d] got ovf=%b bout=%b diff=%h exp %b %b %h",
                         k, u_if.ovf, u_if.bout, u_if.diff, eo[k], eb[k], ed[k]);
            end
            take_result();
        end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        u_if.x = '0; u_if.y = '0; u_if.bin = 1'b0;
        u_if.in_valid = 1'b0; u_if.out_ready = 1'b0;
        test_reset();
        test_vectors();
        test_hold();
        test_reset_mid_op();
        test_back_to_back();
`ifdef SUB_OVERFLOW_FLAG_EN
        test_overflow();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
